// File: rtl/corelet_ctrl.sv
// corelet_ctrl: weight-stationary tile sequencer for the corelet.
// Emits the 35-bit corelet instruction word each cycle for one tile
// (kernel fetch/load, activation fetch/execute, drain, psum readout)
// behind a start/done handshake.
//
// state  | meaning
// -------+--------------------------------------------------------
// IDLE   | waiting for start, inst holds the idle word
// KFETCH | read col weight vectors from xmem, write L0 one cycle later
// KISSUE | pop L0 into the array with kernel load asserted
// KWAIT  | let the kernel settle through the array
// AFETCH | read L activation vectors from xmem into L0
// EXEC   | pop L0 into the array with execute asserted
// DRAIN  | wait out the array pipeline
// READ   | move L results from OFIFO into pmem
// DONE   | one-cycle completion pulse
module corelet_ctrl #(
   parameter int row     = 8,
   parameter int col     = 8,
   parameter int addr_bw = 11,
   parameter int len_bw  = 8
) (
   input  logic               clk,
   input  logic               reset,
   input  logic               start,
   input  logic [addr_bw-1:0] cfg_w_base,
   input  logic [addr_bw-1:0] cfg_a_base,
   input  logic [addr_bw-1:0] cfg_p_base,
   input  logic [len_bw-1:0]  cfg_len,
   input  logic               cfg_acc,
   output logic [34:0]        inst,
   output logic               busy,
   output logic               done
);

   // Counter must reach col, row+col-1 and L; one spare bit keeps it safe.
   localparam int K_W = ((len_bw + 1) > $clog2(row + col + 2)) ? (len_bw + 1)
                                                               : $clog2(row + col + 2);

   localparam logic [3:0] S_IDLE   = 4'd0;
   localparam logic [3:0] S_KFETCH = 4'd1;
   localparam logic [3:0] S_KISSUE = 4'd2;
   localparam logic [3:0] S_KWAIT  = 4'd3;
   localparam logic [3:0] S_AFETCH = 4'd4;
   localparam logic [3:0] S_EXEC   = 4'd5;
   localparam logic [3:0] S_DRAIN  = 4'd6;
   localparam logic [3:0] S_READ   = 4'd7;
   localparam logic [3:0] S_DONE   = 4'd8;

   // Chip enables and write enables deasserted (active-low), everything else 0.
   localparam logic [34:0] IDLE_WORD = (35'd1 << 32) | (35'd1 << 31) |
                                       (35'd1 << 19) | (35'd1 << 18);

   logic [3:0]         state_q, state_d;
   logic [K_W-1:0]     k_q, k_d, k_last;
   logic [addr_bw-1:0] w_base_q, w_base_d;
   logic [addr_bw-1:0] a_base_q, a_base_d;
   logic [addr_bw-1:0] p_base_q, p_base_d;
   logic [len_bw-1:0]  len_q, len_d;
   logic               acc_q, acc_d;
   logic [34:0]        inst_q, inst_d;
   logic               busy_q, busy_d;
   logic               done_q, done_d;

   // Next state, shared phase counter and configuration capture.
   always_comb begin
      state_d  = state_q;
      k_d      = k_q;
      w_base_d = w_base_q;
      a_base_d = a_base_q;
      p_base_d = p_base_q;
      len_d    = len_q;
      acc_d    = acc_q;
      k_last   = '0;
      case (state_q)
         S_KFETCH: k_last = K_W'(col);
         S_KISSUE: k_last = K_W'(col - 1);
         S_KWAIT,
         S_DRAIN:  k_last = K_W'(row + col - 1);
         S_AFETCH: k_last = K_W'(len_q);
         S_EXEC,
         S_READ:   k_last = K_W'(len_q) - K_W'(1);
         default:  k_last = '0;
      endcase
      if (state_q == S_IDLE) begin
         if (start) begin
            state_d  = S_KFETCH;
            k_d      = '0;
            w_base_d = cfg_w_base;
            a_base_d = cfg_a_base;
            p_base_d = cfg_p_base;
            len_d    = cfg_len;
            acc_d    = cfg_acc;
         end
      end else if (k_q == k_last) begin
         k_d = '0;
         case (state_q)
            S_KFETCH: state_d = S_KISSUE;
            S_KISSUE: state_d = S_KWAIT;
            S_KWAIT:  state_d = (len_q == '0) ? S_DONE : S_AFETCH;
            S_AFETCH: state_d = S_EXEC;
            S_EXEC:   state_d = S_DRAIN;
            S_DRAIN:  state_d = S_READ;
            S_READ:   state_d = S_DONE;
            default:  state_d = S_IDLE;
         endcase
      end else begin
         k_d = k_q + K_W'(1);
      end
   end

   // Instruction word for the upcoming cycle, decoded from next state so inst is a flop.
   always_comb begin
      inst_d = IDLE_WORD;
      case (state_d)
         S_KFETCH: begin
            if (k_d < K_W'(col)) begin
               inst_d[19]   = 1'b0;
               inst_d[17:7] = 11'(w_base_d + addr_bw'(k_d));
            end
            if (k_d != '0) inst_d[2] = 1'b1;
         end
         S_KISSUE: begin
            inst_d[3] = 1'b1;
            inst_d[0] = 1'b1;
         end
         S_AFETCH: begin
            if (k_d < K_W'(len_d)) begin
               inst_d[19]   = 1'b0;
               inst_d[17:7] = 11'(a_base_d + addr_bw'(k_d));
            end
            if (k_d != '0) inst_d[2] = 1'b1;
         end
         S_EXEC: begin
            inst_d[3] = 1'b1;
            inst_d[1] = 1'b1;
         end
         S_READ: begin
            inst_d[33]    = acc_d;
            inst_d[32]    = 1'b0;
            inst_d[31]    = 1'b0;
            inst_d[30:20] = 11'(p_base_d + addr_bw'(k_d));
            inst_d[6]     = 1'b1;
         end
         default: inst_d = IDLE_WORD;
      endcase
      busy_d = (state_d != S_IDLE);
      done_d = (state_d == S_DONE);
   end

   // State, configuration and registered outputs with synchronous reset.
   always_ff @(posedge clk) begin
      if (reset) begin
         state_q  <= S_IDLE;
         k_q      <= '0;
         w_base_q <= '0;
         a_base_q <= '0;
         p_base_q <= '0;
         len_q    <= '0;
         acc_q    <= 1'b0;
         inst_q   <= IDLE_WORD;
         busy_q   <= 1'b0;
         done_q   <= 1'b0;
      end else begin
         state_q  <= state_d;
         k_q      <= k_d;
         w_base_q <= w_base_d;
         a_base_q <= a_base_d;
         p_base_q <= p_base_d;
         len_q    <= len_d;
         acc_q    <= acc_d;
         inst_q   <= inst_d;
         busy_q   <= busy_d;
         done_q   <= done_d;
      end
   end

   assign inst = inst_q;
   assign busy = busy_q;
   assign done = done_q;

endmodule

// File: tb/tb_corelet_ctrl.sv
// Bench for corelet_ctrl: stimulus pushes the expected per-cycle instruction
// words and tile lengths into queues; a monitor pops and compares every busy
// cycle and checks the idle word whenever the sequencer is idle.
module tb_corelet_ctrl;
   logic        clk = 1'b0;
   logic        reset, start;
   logic [10:0] cfg_w_base, cfg_a_base, cfg_p_base;
   logic [7:0]  cfg_len;
   logic        cfg_acc;
   logic [34:0] inst;
   logic        busy, done;

   corelet_ctrl #(.row(8), .col(8), .addr_bw(11), .len_bw(8)) dut (
      .clk(clk), .reset(reset), .start(start),
      .cfg_w_base(cfg_w_base), .cfg_a_base(cfg_a_base), .cfg_p_base(cfg_p_base),
      .cfg_len(cfg_len), .cfg_acc(cfg_acc),
      .inst(inst), .busy(busy), .done(done)
   );

   always #5 clk = ~clk;

   localparam logic [34:0] IDLE_W = (35'd1 << 32) | (35'd1 << 31) |
                                    (35'd1 << 19) | (35'd1 << 18);

   int tests = 0;
   int fails = 0;
   logic [34:0] q_inst[$];
   logic        q_done[$];
   int          q_len[$];
   bit          mon_en = 1'b0;
   int          bcnt = 0;
   int          widx = 0;
   logic        prev_busy = 1'b0;
   logic [34:0] m_ei;
   logic        m_ed;
   int          m_el;
   int          gen_n, gen_cut;

   // Monitor: one comparison per cycle once reset has settled the outputs.
   always @(negedge clk) begin
      if (mon_en) begin
         if (busy === 1'b1) begin
            bcnt++;
            tests++;
            if (q_inst.size() == 0) begin
               fails++;
               $display("FAIL unexpected_busy got inst=%h done=%b, expected no tile in flight", inst, done);
            end else begin
               m_ei = q_inst.pop_front();
               m_ed = q_done.pop_front();
               if (inst !== m_ei || done !== m_ed) begin
                  fails++;
                  $display("FAIL tile_word[%0d] got inst=%h done=%b expected inst=%h done=%b",
                           widx, inst, done, m_ei, m_ed);
               end
            end
            widx++;
         end else begin
            tests++;
            if (inst !== IDLE_W || done !== 1'b0 || busy !== 1'b0) begin
               fails++;
               $display("FAIL idle_word got inst=%h busy=%b done=%b expected inst=%h busy=0 done=0",
                        inst, busy, done, IDLE_W);
            end
            if (prev_busy) begin
               tests++;
               m_el = (q_len.size() != 0) ? q_len.pop_front() : -1;
               if (bcnt != m_el) begin
                  fails++;
                  $display("FAIL busy_cycles got %0d expected %0d", bcnt, m_el);
               end
               bcnt = 0;
               widx = 0;
            end
         end
         prev_busy = (busy === 1'b1);
      end
   end

   task automatic push_exp(input logic [34:0] wd, input logic dn);
      if (gen_cut < 0 || gen_n < gen_cut) begin
         q_inst.push_back(wd);
         q_done.push_back(dn);
      end
      gen_n++;
   endtask

   // Expected words for a tile with row=col=8; ncut>=0 keeps only the first ncut words.
   task automatic gen_tile(input logic [10:0] w, input logic [10:0] a, input logic [10:0] p,
                           input int len, input logic acc, input int ncut, input int cycles);
      logic [34:0] wd;
      gen_n = 0;
      gen_cut = ncut;
      for (int k = 0; k <= 8; k++) begin
         wd = IDLE_W;
         if (k < 8) begin wd[19] = 1'b0; wd[17:7] = w + 11'(k); end
         if (k >= 1) wd[2] = 1'b1;
         push_exp(wd, 1'b0);
      end
      for (int k = 0; k < 8; k++) begin
         wd = IDLE_W; wd[3] = 1'b1; wd[0] = 1'b1;
         push_exp(wd, 1'b0);
      end
      for (int k = 0; k < 16; k++) push_exp(IDLE_W, 1'b0);
      if (len > 0) begin
         for (int k = 0; k <= len; k++) begin
            wd = IDLE_W;
            if (k < len) begin wd[19] = 1'b0; wd[17:7] = a + 11'(k); end
            if (k >= 1) wd[2] = 1'b1;
            push_exp(wd, 1'b0);
         end
         for (int k = 0; k < len; k++) begin
            wd = IDLE_W; wd[3] = 1'b1; wd[1] = 1'b1;
            push_exp(wd, 1'b0);
         end
         for (int k = 0; k < 16; k++) push_exp(IDLE_W, 1'b0);
         for (int k = 0; k < len; k++) begin
            wd = IDLE_W;
            wd[33] = acc; wd[32] = 1'b0; wd[31] = 1'b0;
            wd[30:20] = p + 11'(k); wd[6] = 1'b1;
            push_exp(wd, 1'b0);
         end
      end
      push_exp(IDLE_W, 1'b1);
      q_len.push_back((ncut < 0) ? cycles : ncut);
   endtask

   task automatic set_cfg(input logic [10:0] w, input logic [10:0] a, input logic [10:0] p,
                          input int len, input logic acc);
      cfg_w_base = w; cfg_a_base = a; cfg_p_base = p;
      cfg_len = 8'(len); cfg_acc = acc;
   endtask

   task automatic wait_idle();
      for (int i = 0; i < 1000 && busy === 1'b1; i++) @(negedge clk);
      if (busy !== 1'b0) begin
         tests++;
         fails++;
         $display("FAIL idle_timeout got busy=%b expected 0 within 1000 cycles", busy);
      end
   endtask

   // Called right after a falling edge; returns at the first idle falling edge.
   task automatic do_tile(input logic [10:0] w, input logic [10:0] a, input logic [10:0] p,
                          input int len, input logic acc, input int cycles);
      set_cfg(w, a, p, len, acc);
      gen_tile(w, a, p, len, acc, -1, cycles);
      start = 1'b1;
      @(negedge clk);
      start = 1'b0;
      set_cfg(~w, ~a, ~p, 77, ~acc);
      wait_idle();
   endtask

   initial begin
      reset = 1'b1;
      start = 1'b0;
      set_cfg(11'd0, 11'd0, 11'd0, 0, 1'b0);
      repeat (3) @(negedge clk);
      mon_en = 1'b1;
      @(negedge clk);
      reset = 1'b0;
      repeat (10) @(negedge clk);

      // Nominal tile, L=4: 9+8+16+5+4+16+4+1 = 63 busy cycles.
      do_tile(11'd0, 11'd16, 11'd0, 4, 1'b1, 63);
      repeat (2) @(negedge clk);

      // Address wrap on both memories, L=1: 54 busy cycles.
      do_tile(11'd2046, 11'd16, 11'd2047, 1, 1'b0, 54);
      repeat (2) @(negedge clk);

      // L=0: kernel only, 9+8+16+1 = 34 busy cycles.
      do_tile(11'd5, 11'd20, 11'd9, 0, 1'b1, 34);
      repeat (2) @(negedge clk);

      // Starts during EXEC and in the DONE cycle are dropped; a start right after done runs.
      set_cfg(11'd0, 11'd16, 11'd0, 4, 1'b0);
      gen_tile(11'd0, 11'd16, 11'd0, 4, 1'b0, -1, 63);
      start = 1'b1;
      @(negedge clk);
      start = 1'b0;
      repeat (39) @(negedge clk);
      start = 1'b1;
      @(negedge clk);
      start = 1'b0;
      repeat (22) @(negedge clk);
      start = 1'b1;
      set_cfg(11'd8, 11'd40, 11'd100, 2, 1'b1);
      gen_tile(11'd8, 11'd40, 11'd100, 2, 1'b1, -1, 57);
      @(negedge clk);
      @(negedge clk);
      start = 1'b0;
      set_cfg(11'd1, 11'd2, 11'd3, 9, 1'b0);
      wait_idle();
      repeat (2) @(negedge clk);

      // Reset during KISSUE after 12 busy cycles, then a clean tile.
      set_cfg(11'd0, 11'd16, 11'd0, 4, 1'b0);
      gen_tile(11'd0, 11'd16, 11'd0, 4, 1'b0, 12, 63);
      start = 1'b1;
      @(negedge clk);
      start = 1'b0;
      repeat (11) @(negedge clk);
      reset = 1'b1;
      @(negedge clk);
      reset = 1'b0;
      @(negedge clk);
      do_tile(11'd0, 11'd16, 11'd0, 4, 1'b0, 63);
      repeat (2) @(negedge clk);

      // Start coincident with reset is ignored.
      reset = 1'b1;
      start = 1'b1;
      @(negedge clk);
      reset = 1'b0;
      start = 1'b0;
      repeat (4) @(negedge clk);

      tests++;
      if (q_inst.size() != 0 || q_len.size() != 0) begin
         fails++;
         $display("FAIL leftover_expect got %0d words %0d tiles pending expected 0 0",
                  q_inst.size(), q_len.size());
      end
      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end
endmodule
